// File: rtl/id_decode_stage.sv
// MIPS-32 decode stage: register file, control decode, sign extension and load-use stall.
// Define REGFILE_BYPASS_EN to forward a same-cycle WB write onto the read ports.
module id_decode_stage #(
    parameter int NUM_REGS    = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            instr_in,
    input  logic                   WB_RegWrite_in,
    input  logic [4:0]             WB_Write_Reg_in,
    input  logic [31:0]            WB_Write_Data_in,
    input  logic                   ID_EX_MemRead_in,
    input  logic [4:0]             ID_EX_Rt_in,
    output logic                   RegWrite_out,
    output logic                   MemtoReg_out,
    output logic                   MemRead_out,
    output logic                   MemWrite_out,
    output logic                   RegDst_out,
    output logic                   ALU_Src_out,
    output logic [1:0]             ALU_Op_out,
    output logic [31:0]            Read_Data_1_out,
    output logic [31:0]            Read_Data_2_out,
    output logic [31:0]            sign_extend_out,
    output logic [4:0]             IF_ID_Rs_out,
    output logic [4:0]             IF_ID_Rt_out,
    output logic [4:0]             ID_Rd_out,
    output logic                   PC_Write_out,
    output logic                   IF_ID_Write_out,
    output logic [STALL_CNT_W-1:0] stall_count_out
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [31:0] gpr [NUM_REGS];
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        wb_en;
    logic        hz;
    logic        ctrl_en;
    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic [1:0]  alu_op;

    assign opcode          = instr_in[31:26];
    assign rs              = instr_in[25:21];
    assign rt              = instr_in[20:16];
    assign IF_ID_Rs_out    = rs;
    assign IF_ID_Rt_out    = rt;
    assign ID_Rd_out       = instr_in[15:11];
    assign sign_extend_out = {{16{instr_in[15]}}, instr_in[15:0]};

    assign wb_en = WB_RegWrite_in && (WB_Write_Reg_in != 5'd0);

    // The register file keeps committing WB writes even while the front end stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_en) begin
            gpr[WB_Write_Reg_in] <= WB_Write_Data_in;
        end
    end

    always_comb begin
        Read_Data_1_out = (rs == 5'd0) ? 32'd0 : gpr[rs];
        Read_Data_2_out = (rt == 5'd0) ? 32'd0 : gpr[rt];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wb_en && (WB_Write_Reg_in == rs)) begin
            Read_Data_1_out = WB_Write_Data_in;
        end
        if (rst_n && wb_en && (WB_Write_Reg_in == rt)) begin
            Read_Data_2_out = WB_Write_Data_in;
        end
`endif
    end

    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                alu_op = 2'b01;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    // A load in EX whose destination feeds this instruction needs one bubble.
    assign hz = rst_n && ID_EX_MemRead_in && (ID_EX_Rt_in != 5'd0) &&
                ((ID_EX_Rt_in == rs) || (ID_EX_Rt_in == rt));

    assign ctrl_en = rst_n && !hz;

    assign RegWrite_out    = reg_write  && ctrl_en;
    assign MemtoReg_out    = mem_to_reg && ctrl_en;
    assign MemRead_out     = mem_read   && ctrl_en;
    assign MemWrite_out    = mem_write  && ctrl_en;
    assign RegDst_out      = reg_dst    && ctrl_en;
    assign ALU_Src_out     = alu_src    && ctrl_en;
    assign ALU_Op_out      = ctrl_en ? alu_op : 2'b00;
    assign PC_Write_out    = !hz;
    assign IF_ID_Write_out = !hz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_out <= '0;
        end else if (hz && (stall_count_out != '1)) begin
            stall_count_out <= stall_count_out + 1'b1;
        end
    end

endmodule
